// File: rtl/program_memory_pkg.sv
// Shared definitions for the program memory: default geometry and loader FSM states.
package program_memory_pkg;

    localparam int DEF_INSTRUCTION_SIZE      = 16;
    localparam int DEF_INSTRUCTION_ADDR_SIZE = 10;
    localparam int DEF_LOAD_WIDTH            = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSEMBLE = 2'd1,
        ST_WRITE    = 2'd2,
        ST_DONE     = 2'd3
    } load_state_e;

    // Loader beats needed to assemble one instruction word.
    function automatic int beats_per_word(input int word_w, input int beat_w);
        return word_w / beat_w;
    endfunction

endpackage

// File: rtl/program_memory_if.sv
// Fetch and loader signal bundle for program_memory.
// With PROG_MEM_PARITY_EN defined the bundle also carries fetch_parity_err.
interface program_memory_if
    import program_memory_pkg::*;
#(
    parameter int INSTRUCTION_SIZE      = DEF_INSTRUCTION_SIZE,
    parameter int INSTRUCTION_ADDR_SIZE = DEF_INSTRUCTION_ADDR_SIZE,
    parameter int LOAD_WIDTH            = DEF_LOAD_WIDTH
);
    logic                             fetch_req;
    logic [INSTRUCTION_ADDR_SIZE-1:0] fetch_addr;
    logic                             fetch_valid;
    logic [INSTRUCTION_SIZE-1:0]      fetch_data;
    logic                             fetch_stall;
`ifdef PROG_MEM_PARITY_EN
    logic                             fetch_parity_err;
`endif
    logic                             load_start;
    logic                             load_valid;
    logic                             load_ready;
    logic [LOAD_WIDTH-1:0]            load_data;
    logic                             load_end;
    logic [INSTRUCTION_ADDR_SIZE:0]   load_count;
    logic                             load_full;

    modport master (
        output fetch_req, fetch_addr, load_start, load_valid, load_data, load_end,
`ifdef PROG_MEM_PARITY_EN
        input  fetch_parity_err,
`endif
        input  fetch_valid, fetch_data, fetch_stall, load_ready, load_count, load_full
    );

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_valid, load_data, load_end,
`ifdef PROG_MEM_PARITY_EN
        output fetch_parity_err,
`endif
        output fetch_valid, fetch_data, fetch_stall, load_ready, load_count, load_full
    );

endinterface

// File: rtl/program_memory_load_assembler.sv
// Loader word assembler: shifts beats in MSB-first and counts beats within a word.
module load_assembler
    import program_memory_pkg::*;
#(
    parameter int INSTRUCTION_SIZE = DEF_INSTRUCTION_SIZE,
    parameter int LOAD_WIDTH       = DEF_LOAD_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        shift_en,
    input  logic [LOAD_WIDTH-1:0]       beat_data,
    output logic [INSTRUCTION_SIZE-1:0] word,
    output logic                        last_beat
);
    localparam int BEATS = beats_per_word(INSTRUCTION_SIZE, LOAD_WIDTH);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [INSTRUCTION_SIZE-1:0] word_q, word_d;
    logic [CW-1:0]               cnt_q, cnt_d;

    assign word      = word_q;
    assign last_beat = (cnt_q == CW'(BEATS - 1));

    // Clear dominates shift so an aborted load never keeps a stray beat.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            word_d = (word_q << LOAD_WIDTH) | INSTRUCTION_SIZE'(beat_data);
            cnt_d  = last_beat ? '0 : cnt_q + CW'(1);
        end
    end

    // Shift register and beat counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/program_memory.sv
// Program memory with a streaming loader and a single-cycle-latency fetch port.
// Optional feature: define PROG_MEM_PARITY_EN to store an even-parity bit per word
// and flag fetch_parity_err on a mismatching read.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int INSTRUCTION_SIZE      = DEF_INSTRUCTION_SIZE,
    parameter int INSTRUCTION_ADDR_SIZE = DEF_INSTRUCTION_ADDR_SIZE,
    parameter int LOAD_WIDTH            = DEF_LOAD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    program_memory_if.slave  bus
);
    localparam int DEPTH = 2 ** INSTRUCTION_ADDR_SIZE;
    localparam int CNT_W = INSTRUCTION_ADDR_SIZE + 1;
`ifdef PROG_MEM_PARITY_EN
    localparam int MEM_W = INSTRUCTION_SIZE + 1;
`else
    localparam int MEM_W = INSTRUCTION_SIZE;
`endif

    logic [MEM_W-1:0] mem [DEPTH] = '{default: '0};

    load_state_e                 state_q, state_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        full_q, full_d;
    logic                        end_pend_q, end_pend_d;
    logic                        fetch_valid_q, fetch_valid_d;
    logic [INSTRUCTION_SIZE-1:0] fetch_data_q, fetch_data_d;
`ifdef PROG_MEM_PARITY_EN
    logic                        parity_err_q, parity_err_d;
`endif

    logic                        load_ready;
    logic                        beat_xfer;
    logic                        asm_clear;
    logic                        last_beat;
    logic                        mem_we;
    logic                        fetch_accept;
    logic [INSTRUCTION_SIZE-1:0] asm_word;
    logic [MEM_W-1:0]            wr_word;
    logic [MEM_W-1:0]            rd_word;

    load_assembler #(
        .INSTRUCTION_SIZE (INSTRUCTION_SIZE),
        .LOAD_WIDTH       (LOAD_WIDTH)
    ) u_load_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .shift_en  (beat_xfer),
        .beat_data (bus.load_data),
        .word      (asm_word),
        .last_beat (last_beat)
    );

    assign load_ready = (state_q == ST_ASSEMBLE) && !full_q;
    assign beat_xfer  = load_ready && bus.load_valid;

`ifdef PROG_MEM_PARITY_EN
    assign wr_word = {^asm_word, asm_word};
`else
    assign wr_word = asm_word;
`endif
    assign rd_word = mem[bus.fetch_addr];

    // Loader wins over a same-cycle fetch request.
    assign fetch_accept = bus.fetch_req && (state_q == ST_IDLE) && !bus.load_start;

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = fetch_data_q;
    assign bus.fetch_stall = (state_q != ST_IDLE);
    assign bus.load_ready  = load_ready;
    assign bus.load_count  = count_q;
    assign bus.load_full   = full_q;
`ifdef PROG_MEM_PARITY_EN
    assign bus.fetch_parity_err = parity_err_q;
`endif

    // Loader next-state logic; load_count doubles as the write pointer and stops at depth.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        full_d     = full_q;
        end_pend_d = end_pend_q;
        asm_clear  = 1'b0;
        mem_we     = 1'b0;
        if (bus.load_start) begin
            state_d    = ST_ASSEMBLE;
            count_d    = '0;
            full_d     = 1'b0;
            end_pend_d = 1'b0;
            asm_clear  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_ASSEMBLE: begin
                    if (beat_xfer && last_beat) begin
                        // load_end on the completing beat still commits that word.
                        state_d    = ST_WRITE;
                        end_pend_d = bus.load_end;
                    end else if (bus.load_end) begin
                        state_d   = ST_DONE;
                        asm_clear = 1'b1;
                    end
                end
                ST_WRITE: begin
                    mem_we     = 1'b1;
                    count_d    = count_q + CNT_W'(1);
                    end_pend_d = 1'b0;
                    if (count_q == CNT_W'(DEPTH - 1)) begin
                        full_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (bus.load_end || end_pend_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ASSEMBLE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Fetch result; data holds its previous value when no fetch is accepted.
    always_comb begin
        fetch_valid_d = fetch_accept;
        fetch_data_d  = fetch_data_q;
`ifdef PROG_MEM_PARITY_EN
        parity_err_d  = 1'b0;
`endif
        if (fetch_accept) begin
            fetch_data_d = rd_word[INSTRUCTION_SIZE-1:0];
`ifdef PROG_MEM_PARITY_EN
            parity_err_d = ^rd_word;
`endif
        end
    end

    // Control and fetch output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            full_q        <= 1'b0;
            end_pend_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
`ifdef PROG_MEM_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            full_q        <= full_d;
            end_pend_q    <= end_pend_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
`ifdef PROG_MEM_PARITY_EN
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    // Storage array has no reset so words written before a reset survive it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[count_q[INSTRUCTION_ADDR_SIZE-1:0]] <= wr_word;
        end
    end

endmodule

// File: doc/program_memory.md
PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 SHALL have parameter INSTRUCTION_SIZE, default 16, instruction word width in bits.
REQ-002 SHALL have parameter INSTRUCTION_ADDR_SIZE, default 10, address width; depth = 2**INSTRUCTION_ADDR_SIZE.
REQ-003 SHALL have parameter LOAD_WIDTH, default 8, loader beat width; INSTRUCTION_SIZE SHALL be an integer multiple of LOAD_WIDTH.
REQ-004 SHALL have one clock, clk (input, 1); all state updates occur on the rising edge of clk.
REQ-005 SHALL have reset rst (input, 1): asynchronous, active-high.
REQ-006 fetch_req  input  1  request a read at fetch_addr.
REQ-007 fetch_addr  input  INSTRUCTION_ADDR_SIZE  fetch address.
REQ-008 fetch_valid  output  1  fetch_data holds a completed read.
REQ-009 fetch_data  output  INSTRUCTION_SIZE  fetched instruction.
REQ-010 fetch_stall  output  1  memory busy loading; fetch_req ignored.
REQ-011 load_start  input  1  pulse: begin/restart a load at address 0.
REQ-012 load_valid / load_ready  input / output  1  beat handshake; a beat transfers when both are high.
REQ-013 load_data  input  LOAD_WIDTH  beat payload, MSB-first within a word.
REQ-014 load_end  input  1  pulse: finish the load after the current complete word.
REQ-015 load_count  output  INSTRUCTION_ADDR_SIZE+1  words written in the current or last load.
REQ-016 load_full  output  1  sticky: load reached depth; further beats refused.

Function
REQ-017 Loader FSM states SHALL be IDLE, ASSEMBLE, WRITE and DONE.
- IDLE->ASSEMBLE on load_start.
- ASSEMBLE->WRITE after BEATS = INSTRUCTION_SIZE/LOAD_WIDTH beats.
- WRITE->ASSEMBLE, or ->DONE on load_end or load_full.
- DONE->IDLE next cycle.
REQ-018 Beats SHALL shift into a word register MSB-first; WRITE stores the word at the write pointer in one cycle and increments pointer and load_count.
REQ-019 load_ready SHALL be high only in ASSEMBLE with load_full low; it is low in WRITE (one bubble per word).
REQ-020 On the write that makes load_count equal to depth, load_full SHALL set and the FSM SHALL go to DONE; the pointer SHALL NOT wrap.
REQ-021 load_start in any non-IDLE state SHALL abort: discard the partial word, reset pointer and load_count to 0, clear load_full, enter ASSEMBLE.
REQ-022 load_end with a partial word pending SHALL discard the partial word and go to DONE.
REQ-023 load_end in IDLE SHALL be ignored.
REQ-024 fetch_stall SHALL be high in every state except IDLE.
REQ-025 When fetch_req is high and fetch_stall is low, fetch_data SHALL present mem[fetch_addr] on the next edge with fetch_valid high (latency 1); fetch_valid is otherwise low.
REQ-026 fetch_data SHALL hold its last value while fetch_valid is low.
REQ-027 Back-to-back fetches SHALL sustain one result per cycle.
REQ-028 A simultaneous load_start and fetch_req SHALL give the loader priority: no fetch result.

Reset
REQ-029 rst SHALL force: FSM IDLE, pointer 0, load_count 0, load_full 0, fetch_valid 0, fetch_data 0, load_ready 0.
REQ-030 Memory contents SHALL be zero at time 0 and SHALL NOT be cleared by rst.
REQ-031 rst mid-load SHALL keep already-written words and drop the partial word.

Configuration
REQ-032 With PROG_MEM_PARITY_EN defined, each word SHALL store an even-parity bit computed at WRITE.
- Output fetch_parity_err (1) SHALL assert alongside fetch_valid when the recomputed parity mismatches.
- Without the macro, the port and the storage bit SHALL be absent.

Structure
REQ-033 A shared package SHALL hold the loader state enumeration and the default parameter constants.
REQ-034 A sub-module load_assembler (beat shift register plus beat counter) SHALL be instantiated once.

Verification
REQ-035 rst, load_start, beats 81 01 82 01 84 40, load_end -> load_count=3; fetch addr 1 -> one cycle later fetch_valid=1, fetch_data=0x8201.
REQ-036 load_start, beats 81 01 82, load_end -> load_count=1; mem[1] unchanged (0x0000).
REQ-037 INSTRUCTION_ADDR_SIZE=2: stream 10 words -> load_full=1 after the 4th word, load_ready stays 0, load_count=4.
REQ-038 fetch_req held high during a load -> fetch_stall=1, fetch_valid=0 throughout; first valid one cycle after IDLE.
REQ-039 rst asserted mid-word after 2 complete words -> outputs at reset values immediately; fetch addrs 0 and 1 return the loaded words.
REQ-040 PROG_MEM_PARITY_EN: force-flip the stored bit of addr 0, fetch addr 0 -> fetch_parity_err=1 with fetch_valid=1.
